// File: rtl/decode_queue.sv
// Decode queue: buffers fetch groups, decodes each instruction on enqueue and
// presents up to DECODE_WIDTH in-order decoded ops per cycle to rename/dispatch.

package decode_queue_pkg;

  typedef enum logic [2:0] {
    FU_NONE   = 3'd0,
    FU_ALU    = 3'd1,
    FU_MUL    = 3'd2,
    FU_LSU    = 3'd3,
    FU_BRANCH = 3'd4
  } e_functional_unit;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } e_format;

  typedef struct packed {
    logic [31:0] insn;
    e_format     encoding;
  } op_t;

  typedef struct packed {
    e_functional_unit fu;
    e_format          fmt;
    logic             illegal;
  } dec_t;

  // Ops table keyed on the RV32/RV64 major opcode; funct7=0000001 selects the multiplier.
  function automatic dec_t decode_insn(input logic [31:0] insn);
    dec_t d;
    d.fu      = FU_NONE;
    d.fmt     = FMT_NONE;
    d.illegal = 1'b0;
    case (insn[6:0])
      7'b0110011, 7'b0111011: begin
        d.fu  = (insn[31:25] == 7'b0000001) ? FU_MUL : FU_ALU;
        d.fmt = FMT_R;
      end
      7'b0010011, 7'b0011011: begin
        d.fu  = FU_ALU;
        d.fmt = FMT_I;
      end
      7'b0000011: begin
        d.fu  = FU_LSU;
        d.fmt = FMT_I;
      end
      7'b0100011: begin
        d.fu  = FU_LSU;
        d.fmt = FMT_S;
      end
      7'b1100011: begin
        d.fu  = FU_BRANCH;
        d.fmt = FMT_B;
      end
      7'b1101111: begin
        d.fu  = FU_BRANCH;
        d.fmt = FMT_J;
      end
      7'b1100111: begin
        d.fu  = FU_BRANCH;
        d.fmt = FMT_I;
      end
      7'b0110111, 7'b0010111: begin
        d.fu  = FU_ALU;
        d.fmt = FMT_U;
      end
      7'b0001111, 7'b1110011: begin
        d.fu  = FU_ALU;
        d.fmt = FMT_I;
      end
      default: begin
        d.fu      = FU_NONE;
        d.fmt     = FMT_NONE;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush,
  input  logic                                      in_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]          in_count,
  input  logic [31:0]                               in_pc,
  input  logic [FETCH_WIDTH-1:0][31:0]              in_insn,
  output logic                                      in_ready,
  output logic [DECODE_WIDTH-1:0]                   out_valid,
  output e_functional_unit [DECODE_WIDTH-1:0]       out_rs_id,
  output op_t [DECODE_WIDTH-1:0]                    out_op,
  output logic [DECODE_WIDTH-1:0][31:0]             out_pc,
  output logic [DECODE_WIDTH-1:0]                   out_illegal,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0]         out_take,
  output logic [$clog2(DEPTH+1)-1:0]                occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int CW = $clog2(FETCH_WIDTH+1);
  localparam int TW = $clog2(DECODE_WIDTH+1);

  logic [31:0]      r_insn [DEPTH];
  e_format          r_fmt  [DEPTH];
  e_functional_unit r_fu   [DEPTH];
  logic [31:0]      r_pc   [DEPTH];
  logic             r_ill  [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [OW-1:0] r_occ;

  logic [CW-1:0] w_cnt;
  logic          w_push;
  logic [TW-1:0] w_avail;
  logic [TW-1:0] w_take;
  logic [OW-1:0] w_pushed;
  logic [OW-1:0] w_taken;
  logic [PW-1:0] w_wr_idx [FETCH_WIDTH];
  dec_t          w_dec    [FETCH_WIDTH];

  assign occupancy = r_occ;
  assign in_ready  = (OW'(DEPTH) - r_occ) >= OW'(FETCH_WIDTH);

  // Oversized groups clamp to the fetch width; an empty group is simply a no-op.
  always_comb begin
    w_cnt = (in_count > CW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : in_count;
    w_push = in_valid && in_ready && !flush && (w_cnt != '0);
    w_pushed = w_push ? OW'(w_cnt) : '0;
    w_avail = (r_occ >= OW'(DECODE_WIDTH)) ? TW'(DECODE_WIDTH) : TW'(r_occ);
    w_take = flush ? '0 : ((out_take > w_avail) ? w_avail : out_take);
    w_taken = OW'(w_take);
  end

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      w_wr_idx[k] = r_tail + PW'(k);
      w_dec[k]    = decode_insn(in_insn[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (flush) begin
      r_tail <= r_head;
      r_occ  <= '0;
    end else begin
      r_head <= r_head + PW'(w_take);
      if (w_push) begin
        r_tail <= r_tail + PW'(w_cnt);
      end
      r_occ <= r_occ + w_pushed - w_taken;
    end
  end

  // Entry storage is intentionally unreset; validity is tracked by occupancy alone.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (w_push && (k < int'(w_cnt))) begin
        r_insn[w_wr_idx[k]] <= in_insn[k];
        r_fmt[w_wr_idx[k]]  <= w_dec[k].fmt;
        r_fu[w_wr_idx[k]]   <= w_dec[k].fu;
        r_ill[w_wr_idx[k]]  <= w_dec[k].illegal;
        r_pc[w_wr_idx[k]]   <= in_pc + 32'(4 * k);
      end
    end
  end

  // Invalid lanes are forced to zero so stale or unwritten storage never leaks out as X.
  always_comb begin
    logic [PW-1:0] idx;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      idx = r_head + PW'(i);
      out_valid[i] = r_occ > OW'(i);
      if (out_valid[i]) begin
        out_rs_id[i]       = r_fu[idx];
        out_op[i].insn     = r_insn[idx];
        out_op[i].encoding = r_fmt[idx];
        out_pc[i]          = r_pc[idx];
        out_illegal[i]     = r_ill[idx];
      end else begin
        out_rs_id[i]       = FU_NONE;
        out_op[i].insn     = '0;
        out_op[i].encoding = FMT_NONE;
        out_pc[i]          = '0;
        out_illegal[i]     = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue: decode, full/backpressure,
// illegal opcodes, PC wrap, pointer wrap ordering, flush and async reset.

module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int FW = 2;
  localparam int DW = 2;
  localparam int DEPTH = 8;

  localparam logic [31:0] ADD  = 32'h0020_81B3;
  localparam logic [31:0] LW   = 32'h0000_A183;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] LUI  = 32'h0000_00B7;
  localparam logic [31:0] SW   = 32'h0020_A023;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BAD  = 32'h0000_007F;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic in_valid;
  logic [1:0] in_count;
  logic [31:0] in_pc;
  logic [FW-1:0][31:0] in_insn;
  logic in_ready;
  logic [DW-1:0] out_valid;
  e_functional_unit [DW-1:0] out_rs_id;
  op_t [DW-1:0] out_op;
  logic [DW-1:0][31:0] out_pc;
  logic [DW-1:0] out_illegal;
  logic [1:0] out_take;
  logic [3:0] occupancy;

  int checkCount = 0;
  int failCount = 0;

  decode_queue #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_count(in_count), .in_pc(in_pc), .in_insn(in_insn), .in_ready(in_ready),
    .out_valid(out_valid), .out_rs_id(out_rs_id), .out_op(out_op),
    .out_pc(out_pc), .out_illegal(out_illegal), .out_take(out_take),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] cnt, input logic [31:0] pc,
                               input logic [31:0] i0, input logic [31:0] i1,
                               input logic [1:0] take, input logic fl);
    in_valid   = v;
    in_count   = cnt;
    in_pc      = pc;
    in_insn[0] = i0;
    in_insn[1] = i1;
    out_take   = take;
    flush      = fl;
  endtask

  // Lets one active edge pass, then samples 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] drainPc [8];

  initial begin
    drainPc = '{32'h208, 32'h20C, 32'h210, 32'h214, 32'h218, 32'h21C, 32'h300, 32'h304};
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_occ", 64'(occupancy), 64'd0);
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_ready", 64'(in_ready), 64'd1);
    #10 rst_n = 1'b1;

    // Basic decode of an ADD/LOAD pair
    applyStimulus(1'b1, 2'd2, 32'h100, ADD, LW, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    checkOutput("t1_valid", 64'(out_valid), 64'b11);
    checkOutput("t1_pc0", 64'(out_pc[0]), 64'h100);
    checkOutput("t1_pc1", 64'(out_pc[1]), 64'h104);
    checkOutput("t1_fu0", 64'(out_rs_id[0]), 64'd1);
    checkOutput("t1_fu1", 64'(out_rs_id[1]), 64'd3);
    checkOutput("t1_op0", 64'(out_op[0]), {29'd0, ADD, 3'd1});
    checkOutput("t1_op1", 64'(out_op[1]), {29'd0, LW, 3'd2});
    checkOutput("t1_ill", 64'(out_illegal), 64'd0);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);
    tick();
    checkOutput("t1_drain", 64'(occupancy), 64'd0);

    // Fill with four groups, then hold a fifth
    for (int g = 0; g < 4; g++) begin
      applyStimulus(1'b1, 2'd2, 32'h200 + 32'(8 * g), ADDI, ADDI, 2'd0, 1'b0);
      tick();
    end
    checkOutput("t2_occ_full", 64'(occupancy), 64'd8);
    checkOutput("t2_ready_full", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 2'd2, 32'h300, ADDI, ADDI, 2'd0, 1'b0);
    tick();
    checkOutput("t2_occ_held", 64'(occupancy), 64'd8);
    checkOutput("t2_head_pc", 64'(out_pc[0]), 64'h200);

    // Take while full: push rejected this cycle, accepted next
    applyStimulus(1'b1, 2'd2, 32'h300, ADDI, ADDI, 2'd2, 1'b0);
    tick();
    checkOutput("t3_occ6", 64'(occupancy), 64'd6);
    checkOutput("t3_head_pc", 64'(out_pc[0]), 64'h208);
    checkOutput("t3_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 2'd2, 32'h300, ADDI, ADDI, 2'd0, 1'b0);
    tick();
    checkOutput("t3_occ8", 64'(occupancy), 64'd8);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d_pc0", i), 64'(out_pc[0]), 64'(drainPc[2 * i]));
      checkOutput($sformatf("drain%0d_pc1", i), 64'(out_pc[1]), 64'(drainPc[2 * i + 1]));
      tick();
    end
    checkOutput("drain_occ", 64'(occupancy), 64'd0);
    checkOutput("drain_valid", 64'(out_valid), 64'd0);

    // Single-entry group, then over-take is ignored
    applyStimulus(1'b1, 2'd1, 32'h500, LUI, ADDI, 2'd0, 1'b0);
    tick();
    checkOutput("one_valid", 64'(out_valid), 64'b01);
    checkOutput("one_fu", 64'(out_rs_id[0]), 64'd1);
    checkOutput("one_fmt", 64'(out_op[0].encoding), 64'd5);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);
    tick();
    checkOutput("overtake_occ", 64'(occupancy), 64'd0);
    applyStimulus(1'b1, 2'd0, 32'h580, ADDI, ADDI, 2'd0, 1'b0);
    tick();
    checkOutput("count0_occ", 64'(occupancy), 64'd0);

    // Illegal opcode
    applyStimulus(1'b1, 2'd2, 32'h600, BAD, NOP, 2'd0, 1'b0);
    tick();
    checkOutput("ill_flags", 64'(out_illegal), 64'b01);
    checkOutput("ill_fu0", 64'(out_rs_id[0]), 64'd0);
    checkOutput("ill_fmt0", 64'(out_op[0].encoding), 64'd0);
    checkOutput("ill_fu1", 64'(out_rs_id[1]), 64'd1);
    checkOutput("ill_noX", 64'($isunknown({out_valid, out_rs_id, out_op, out_pc, out_illegal,
                                          occupancy, in_ready})), 64'd0);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);
    tick();

    // PC wrap with clamped in_count
    applyStimulus(1'b1, 2'd3, 32'hFFFF_FFFC, ADD, SW, 2'd0, 1'b0);
    tick();
    checkOutput("wrap_occ", 64'(occupancy), 64'd2);
    checkOutput("wrap_pc0", 64'(out_pc[0]), 64'hFFFF_FFFC);
    checkOutput("wrap_pc1", 64'(out_pc[1]), 64'h0);
    checkOutput("wrap_fu1", 64'(out_rs_id[1]), 64'd3);
    checkOutput("wrap_fmt1", 64'(out_op[1].encoding), 64'd3);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);
    tick();

    // Flush with simultaneous push and take
    applyStimulus(1'b1, 2'd2, 32'h700, ADDI, ADDI, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd2, 32'h708, ADDI, ADDI, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd1, 32'h710, ADDI, ADDI, 2'd0, 1'b0);
    tick();
    checkOutput("fl_occ5", 64'(occupancy), 64'd5);
    applyStimulus(1'b1, 2'd2, 32'h720, ADDI, ADDI, 2'd2, 1'b1);
    tick();
    checkOutput("fl_occ", 64'(occupancy), 64'd0);
    checkOutput("fl_valid", 64'(out_valid), 64'd0);
    checkOutput("fl_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 2'd1, 32'h800, ADDI, ADDI, 2'd0, 1'b0);
    tick();
    checkOutput("fl_after_occ", 64'(occupancy), 64'd1);
    checkOutput("fl_after_pc", 64'(out_pc[0]), 64'h800);

    // Asynchronous reset mid-operation
    applyStimulus(1'b1, 2'd2, 32'h900, ADDI, ADDI, 2'd0, 1'b0);
    tick();
    checkOutput("mid_occ3", 64'(occupancy), 64'd3);
    applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_occ", 64'(occupancy), 64'd0);
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_ready", 64'(in_ready), 64'd1);
    #10 rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
